dispensador_troco: RTL and testbench

- Downstream of `vm`; consumes its change request (`dar_troco` strobe plus `valor_troco` amount).
- Pays the amount out as a sequence of single-coin ejection pulses, largest denomination first, using per-denomination stock counters.
- Reports busy, completion and a shortfall condition when stock cannot cover the amount.
- Instantiated next to `vm` in the top-level bench.

---
 rtl/dispensador_troco.sv | 197 +++++++++++++++++++
 tb/tb_dispensador_troco.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dispensador_troco.sv
// Change dispenser: pays an 8-bit amount as single-coin pulses, largest denomination first,
// drawing on six per-denomination stock counters and flagging a shortfall when stock runs out.
module dispensador_troco #(
    parameter int ESTOQUE_INICIAL = 20,
    parameter int PULSE_CYCLES    = 2,
    parameter int GAP_CYCLES      = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dar_troco,
    input  logic [7:0] valor_troco,
    input  logic       reabastecer,
    output logic       moeda_valida,
    output logic [2:0] moeda_tipo,
    output logic       ocupado,
    output logic       concluido,
    output logic       sem_troco,
    output logic [7:0] restante,
    output logic [7:0] moedas_entregues
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4,
        S_ERRO   = 3'd5
    } estado_t;

    localparam logic [7:0] ESTOQUE_CHEIO = 8'(ESTOQUE_INICIAL);
    localparam logic [7:0] PULSE_ULTIMO  = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_ULTIMO    = 8'(GAP_CYCLES - 1);

    function automatic logic [7:0] valor_moeda(input logic [2:0] idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = 8'd100;
            3'd1:    v = 8'd50;
            3'd2:    v = 8'd25;
            3'd3:    v = 8'd10;
            3'd4:    v = 8'd5;
            3'd5:    v = 8'd1;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    estado_t    estado_q, estado_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] tipo_q, tipo_d;
    logic [7:0] restante_q, restante_d;
    logic [7:0] entregues_q, entregues_d;
    logic       sem_q, sem_d;
    logic [7:0] estoque_q [6];
    logic [7:0] estoque_d [6];

    logic [5:0] candidato_s;
    logic       achou_s;
    logic [2:0] idx_s;

    // Mark every denomination that fits in the amount owed and still has stock.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            candidato_s[i] = (valor_moeda(3'(i)) <= restante_q) && (estoque_q[i] != 8'd0);
        end
    end

    // Priority pick: lowest index is the largest coin.
    always_comb begin
        achou_s = 1'b1;
        idx_s   = 3'd0;
        casez (candidato_s)
            6'b?????1: idx_s = 3'd0;
            6'b????10: idx_s = 3'd1;
            6'b???100: idx_s = 3'd2;
            6'b??1000: idx_s = 3'd3;
            6'b?10000: idx_s = 3'd4;
            6'b100000: idx_s = 3'd5;
            default: begin
                achou_s = 1'b0;
                idx_s   = 3'd0;
            end
        endcase
    end

    // Next-state and datapath updates for the payout sequence.
    always_comb begin
        estado_d    = estado_q;
        cnt_d       = cnt_q;
        tipo_d      = tipo_q;
        restante_d  = restante_q;
        entregues_d = entregues_q;
        sem_d       = sem_q;
        for (int i = 0; i < 6; i++) begin
            estoque_d[i] = estoque_q[i];
        end

        case (estado_q)
            S_IDLE: begin
                if (dar_troco) begin
                    sem_d       = 1'b0;
                    entregues_d = 8'd0;
                    restante_d  = valor_troco;
                    cnt_d       = 8'd0;
                    if (valor_troco != 8'd0) begin
                        estado_d = S_SELECT;
                    end else begin
                        estado_d = S_DONE;
                    end
                end else if (reabastecer) begin
                    for (int i = 0; i < 6; i++) begin
                        estoque_d[i] = ESTOQUE_CHEIO;
                    end
                end else begin
                    estado_d = S_IDLE;
                end
            end
            S_SELECT: begin
                cnt_d = 8'd0;
                if (achou_s) begin
                    tipo_d   = idx_s;
                    estado_d = S_PULSE;
                end else if (restante_q == 8'd0) begin
                    estado_d = S_DONE;
                end else begin
                    estado_d = S_ERRO;
                end
            end
            S_PULSE: begin
                // The coin is only booked on the final pulse edge, so an abort never counts it.
                if (cnt_q == PULSE_ULTIMO) begin
                    restante_d        = restante_q - valor_moeda(tipo_q);
                    estoque_d[tipo_q] = estoque_q[tipo_q] - 8'd1;
                    entregues_d       = (entregues_q == 8'hFF) ? entregues_q : entregues_q + 8'd1;
                    cnt_d             = 8'd0;
                    estado_d          = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_ULTIMO) begin
                    cnt_d    = 8'd0;
                    estado_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                restante_d = 8'd0;
                estado_d   = S_IDLE;
            end
            S_ERRO: begin
                sem_d    = 1'b1;
                estado_d = S_IDLE;
            end
            default: begin
                estado_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= S_IDLE;
            cnt_q       <= 8'd0;
            tipo_q      <= 3'd0;
            restante_q  <= 8'd0;
            entregues_q <= 8'd0;
            sem_q       <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                estoque_q[i] <= ESTOQUE_CHEIO;
            end
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            tipo_q      <= tipo_d;
            restante_q  <= restante_d;
            entregues_q <= entregues_d;
            sem_q       <= sem_d;
            for (int i = 0; i < 6; i++) begin
                estoque_q[i] <= estoque_d[i];
            end
        end
    end

    assign moeda_valida     = (estado_q == S_PULSE);
    assign moeda_tipo       = tipo_q;
    assign ocupado          = (estado_q != S_IDLE);
    assign concluido        = (estado_q == S_DONE);
    assign sem_troco        = sem_q;
    assign restante         = restante_q;
    assign moedas_entregues = entregues_q;

endmodule

// File: tb/tb_dispensador_troco.sv
// Directed bench for dispensador_troco: a default-stock instance and a one-coin-stock instance
// driven from a vector table plus hand-written reset and restock sequences.
module tb_dispensador_troco;

    logic       clock;
    logic       rst0, dt0, rb0;
    logic [7:0] v0;
    logic       mv0, oc0, cc0, st0;
    logic [2:0] mt0;
    logic [7:0] re0, me0;
    logic       rst1, dt1, rb1;
    logic [7:0] v1;
    logic       mv1, oc1, cc1, st1;
    logic [2:0] mt1;
    logic [7:0] re1, me1;

    int n_cmp = 0;
    int n_err = 0;
    int q0[$];
    int q1[$];

    dispensador_troco u_dut0 (
        .clock(clock), .reset(rst0), .dar_troco(dt0), .valor_troco(v0), .reabastecer(rb0),
        .moeda_valida(mv0), .moeda_tipo(mt0), .ocupado(oc0), .concluido(cc0),
        .sem_troco(st0), .restante(re0), .moedas_entregues(me0)
    );

    dispensador_troco #(.ESTOQUE_INICIAL(1)) u_dut1 (
        .clock(clock), .reset(rst1), .dar_troco(dt1), .valor_troco(v1), .reabastecer(rb1),
        .moeda_valida(mv1), .moeda_tipo(mt1), .ocupado(oc1), .concluido(cc1),
        .sem_troco(st1), .restante(re1), .moedas_entregues(me1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nome, input int atual, input int esperado);
        n_cmp++;
        if (atual != esperado) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    // Coin monitors: log each coin and verify every complete pulse lasts two cycles.
    logic vp0 = 1'b0;
    logic vp1 = 1'b0;
    int   pl0 = 0;
    int   pl1 = 0;
    always @(negedge clock) begin
        if (mv0) begin
            if (!vp0) begin q0.push_back(int'(mt0)); pl0 = 1; end
            else pl0++;
        end else if (vp0 && !rst0) begin
            chk("pulse_len0", pl0, 2);
        end
        vp0 = mv0;
        if (mv1) begin
            if (!vp1) begin q1.push_back(int'(mt1)); pl1 = 1; end
            else pl1++;
        end else if (vp1 && !rst1) begin
            chk("pulse_len1", pl1, 2);
        end
        vp1 = mv1;
    end

    typedef struct {
        int         sel;
        logic [7:0] valor;
        logic       rab;
        int         inj;
        int         n;
        logic [23:0] coins;
        logic       concl;
        int         concl_k;
        logic       sem;
        logic [7:0] rest;
        logic [7:0] ent;
    } vec_t;

    vec_t tab [9];

    function automatic logic [23:0] pk(input int c0, c1, c2, c3, c4, c5, c6, c7);
        return {3'(c7), 3'(c6), 3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    endfunction

    task automatic drive(input int sel, input logic dt, input logic [7:0] v, input logic rb);
        if (sel == 0) begin dt0 = dt; v0 = v; rb0 = rb; end
        else begin dt1 = dt; v1 = v; rb1 = rb; end
    endtask

    task automatic apply_row(input int i);
        vec_t t;
        int k, cn, ck, fk;
        logic done, c, o;
        int q[$];
        logic [23:0] cw;
        t = tab[i];
        if (t.sel == 0) q0.delete(); else q1.delete();
        @(negedge clock);
        drive(t.sel, 1'b1, t.valor, t.rab);
        @(posedge clock);
        @(negedge clock);
        drive(t.sel, 1'b0, 8'd0, 1'b0);
        k = 0; cn = 0; ck = -1; fk = -1; done = 1'b0;
        c = (t.sel == 0) ? cc0 : cc1;
        o = (t.sel == 0) ? oc0 : oc1;
        if (c) begin cn++; ck = k; end
        if (!o) begin done = 1'b1; fk = k; end
        while (!done && k < 500) begin
            if (k == t.inj) drive(t.sel, 1'b1, 8'd50, 1'b0);
            else drive(t.sel, 1'b0, 8'd0, 1'b0);
            @(posedge clock);
            k++;
            @(negedge clock);
            c = (t.sel == 0) ? cc0 : cc1;
            o = (t.sel == 0) ? oc0 : oc1;
            if (c) begin cn++; ck = k; end
            if (!o) begin done = 1'b1; fk = k; end
        end
        drive(t.sel, 1'b0, 8'd0, 1'b0);
        chk($sformatf("row%0d_finished", i), int'(done), 1);
        q = (t.sel == 0) ? q0 : q1;
        cw = t.coins;
        chk($sformatf("row%0d_n_coins", i), q.size(), t.n);
        for (int j = 0; j < t.n && j < q.size(); j++) begin
            chk($sformatf("row%0d_coin%0d", i, j), q[j], int'(cw[3*j +: 3]));
        end
        chk($sformatf("row%0d_concluido_count", i), cn, int'(t.concl));
        if (t.concl) begin
            chk($sformatf("row%0d_concluido_edge", i), ck, t.concl_k);
            chk($sformatf("row%0d_ocupado_fall", i), fk, t.concl_k + 1);
        end
        chk($sformatf("row%0d_sem_troco", i), int'((t.sel == 0) ? st0 : st1), int'(t.sem));
        chk($sformatf("row%0d_restante", i), int'((t.sel == 0) ? re0 : re1), int'(t.rest));
        chk($sformatf("row%0d_entregues", i), int'((t.sel == 0) ? me0 : me1), int'(t.ent));
    endtask

    initial begin
        int w;
        logic seen;
        tab[0] = '{0, 8'd186, 1'b0, -1, 5, pk(0,1,2,3,5,0,0,0), 1'b1, 21, 1'b0, 8'd0, 8'd5};
        tab[1] = '{0, 8'd255, 1'b0, -1, 4, pk(0,0,1,4,0,0,0,0), 1'b1, 17, 1'b0, 8'd0, 8'd4};
        tab[2] = '{0, 8'd99,  1'b0, -1, 8, pk(1,2,3,3,5,5,5,5), 1'b1, 33, 1'b0, 8'd0, 8'd8};
        tab[3] = '{0, 8'd30,  1'b0,  1, 2, pk(2,4,0,0,0,0,0,0), 1'b1,  9, 1'b0, 8'd0, 8'd2};
        tab[4] = '{0, 8'd0,   1'b0, -1, 0, pk(0,0,0,0,0,0,0,0), 1'b1,  0, 1'b0, 8'd0, 8'd0};
        tab[5] = '{1, 8'd200, 1'b0, -1, 6, pk(0,1,2,3,4,5,0,0), 1'b0,  0, 1'b1, 8'd9, 8'd6};
        tab[6] = '{1, 8'd0,   1'b0, -1, 0, pk(0,0,0,0,0,0,0,0), 1'b1,  0, 1'b0, 8'd0, 8'd0};
        tab[7] = '{1, 8'd9,   1'b0, -1, 2, pk(4,5,0,0,0,0,0,0), 1'b0,  0, 1'b1, 8'd3, 8'd2};
        tab[8] = '{0, 8'd1,   1'b1, -1, 1, pk(5,0,0,0,0,0,0,0), 1'b1,  5, 1'b0, 8'd0, 8'd1};

        rst0 = 1'b1; rst1 = 1'b1;
        drive(0, 1'b0, 8'd0, 1'b0);
        drive(1, 1'b0, 8'd0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valida", int'(mv0), 0);
        chk("rst_tipo", int'(mt0), 0);
        chk("rst_ocupado", int'(oc0), 0);
        chk("rst_concluido", int'(cc0), 0);
        chk("rst_sem", int'(st0), 0);
        chk("rst_restante", int'(re0), 0);
        chk("rst_entregues", int'(me0), 0);
        chk("rst_estoque0", int'(u_dut0.estoque_q[0]), 20);
        chk("rst_estoque1_dut1", int'(u_dut1.estoque_q[5]), 1);
        rst0 = 1'b0; rst1 = 1'b0;

        for (int i = 0; i <= 6; i++) apply_row(i);

        // Restock the exhausted one-coin instance, then pay 9 from a single coin of each kind.
        @(negedge clock);
        drive(1, 1'b0, 8'd0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        drive(1, 1'b0, 8'd0, 1'b0);
        chk("restock_ocupado", int'(oc1), 0);
        chk("restock_estoque4", int'(u_dut1.estoque_q[4]), 1);
        apply_row(7);

        // Reset during the first coin pulse aborts the transaction.
        q0.delete();
        @(negedge clock);
        drive(0, 1'b1, 8'd100, 1'b0);
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 8'd0, 1'b0);
        seen = 1'b0;
        w = 0;
        while (!seen && w < 20) begin
            if (mv0) seen = 1'b1;
            else begin @(posedge clock); @(negedge clock); w++; end
        end
        chk("abort_pulse_seen", int'(seen), 1);
        rst0 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_valida", int'(mv0), 0);
        chk("abort_tipo", int'(mt0), 0);
        chk("abort_ocupado", int'(oc0), 0);
        chk("abort_concluido", int'(cc0), 0);
        chk("abort_restante", int'(re0), 0);
        chk("abort_entregues", int'(me0), 0);
        chk("abort_estoque0", int'(u_dut0.estoque_q[0]), 20);
        @(posedge clock);
        @(negedge clock);
        rst0 = 1'b0;

        // Request together with restock: request served, restock dropped.
        apply_row(8);
        chk("both_estoque5", int'(u_dut0.estoque_q[5]), 19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
